ps_shift_register: RTL and testbench

//   Parallel-in, serial-out (PISO) shift register for the SPI transmit path.
//   - A WIDTH-bit parallel word is captured on a load cycle.
//   - The word is then shifted out MSB-first on a single serial data line, one bit per clock.
//   - Sits between the message source and the SPI serial output pin driver.
//

---
 rtl/ps_shift_register_if.sv | 27 ++
 rtl/ps_shift_register.sv | 49 ++++
 tb/tb_ps_shift_register.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ps_shift_register_if.sv
// Parallel-load/serial-out bus between the message source and the SPI transmit shift register.
// The master side supplies the parallel word and the load/shift select. The slave side
// returns the serial bit and the empty flag.
interface ps_shift_register_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] message;
  logic             ld;
  logic             dat;
  logic             empty;

  modport master (
    output message,
    output ld,
    input  dat,
    input  empty
  );

  modport slave (
    input  message,
    input  ld,
    output dat,
    output empty
  );

endinterface

// File: rtl/ps_shift_register.sv
// PISO shift register for the SPI transmit path.
// A parallel word is captured when ld is low. While ld is high, the word is then shifted
// out MSB-first with one bit per clock. A bit counter tracks how many loaded bits have not
// yet been presented, so empty rises once the whole word has appeared on dat. After that,
// the register keeps shifting in FILL and the counter stays at zero.
module ps_shift_register #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  ps_shift_register_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next state: a low ld captures a new word and discards any unsent bits; otherwise shift with a saturating count.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (!bus.ld) begin
      sr_d  = bus.message;
      cnt_d = CW'(WIDTH);
    end else begin
      sr_d = {sr_q[WIDTH-2:0], FILL};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State register: synchronous reset beats both load and shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.dat   = sr_q[WIDTH-1];
  assign bus.empty = (cnt_q == '0);

endmodule

// File: tb/tb_ps_shift_register.sv
// Self-checking bench for ps_shift_register.
// The reference model treats the output as a bit stream: the captured word followed by
// an endless run of FILL bits. It also keeps a separate count of loaded bits not yet shown.
module tb_ps_shift_register;

  localparam int   WIDTH = 4;
  localparam logic FILL  = 1'b0;

  logic clock;
  logic reset;

  ps_shift_register_if #(.WIDTH(WIDTH)) bus ();

  ps_shift_register #(
    .WIDTH (WIDTH),
    .FILL  (FILL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int assertCount;
  int failCount;

  // Reference model state.
  logic [WIDTH-1:0] modelWord;
  int               modelPos;
  int               modelRemain;

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic expDat();
    if (modelPos < WIDTH) return modelWord[WIDTH-1-modelPos];
    return FILL;
  endfunction

  function automatic logic expEmpty();
    return (modelRemain == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one clock's worth of inputs, advance the model on the edge, then check just after it.
  task automatic applyStimulus(input logic r, input logic l, input logic [WIDTH-1:0] m, input string tag);
    reset       = r;
    bus.ld      = l;
    bus.message = m;
    @(posedge clock);
    if (r) begin
      modelWord   = '0;
      modelPos    = 0;
      modelRemain = 0;
    end else if (!l) begin
      modelWord   = m;
      modelPos    = 0;
      modelRemain = WIDTH;
    end else begin
      if (modelPos < WIDTH) modelPos++;
      if (modelRemain > 0) modelRemain--;
    end
    #1;
    checkOutput({tag, ".dat"},   32'(bus.dat),   32'(expDat()));
    checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(expEmpty()));
  endtask

  // Directed cases first, then a randomized mix of load, shift and reset.
  initial begin
    assertCount = 0;
    failCount   = 0;
    modelWord   = '0;
    modelPos    = 0;
    modelRemain = 0;
    reset       = 1'b1;
    bus.ld      = 1'b0;
    bus.message = '1;
    @(negedge clock);

    // Reset beats load.
    applyStimulus(1'b1, 1'b0, 4'b1111, "rst0");
    applyStimulus(1'b1, 1'b0, 4'b1111, "rst1");
    checkOutput("rstDatConst", 32'(bus.dat), 32'd0);
    checkOutput("rstEmptyConst", 32'(bus.empty), 32'd1);

    // Load 1110, then shift out with three more shifts past exhaustion.
    applyStimulus(1'b0, 1'b0, 4'b1110, "ld1110");
    checkOutput("ldMsbConst", 32'(bus.dat), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 4'b0000, $sformatf("sh%0d", i));
    checkOutput("exhaustDatConst", 32'(bus.dat), 32'(FILL));
    checkOutput("exhaustEmptyConst", 32'(bus.empty), 32'd1);

    // Reload mid-word.
    applyStimulus(1'b0, 1'b0, 4'b1010, "ld1010");
    applyStimulus(1'b0, 1'b1, 4'b0000, "midSh");
    applyStimulus(1'b0, 1'b0, 4'b0111, "ld0111");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'b1111, $sformatf("reSh%0d", i));

    // Reset mid-word.
    applyStimulus(1'b0, 1'b0, 4'b1001, "ld1001");
    applyStimulus(1'b0, 1'b1, 4'b0000, "pre0");
    applyStimulus(1'b0, 1'b1, 4'b0000, "pre1");
    applyStimulus(1'b1, 1'b1, 4'b1111, "midRst");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'b1111, $sformatf("postRst%0d", i));

    // Message changes while shifting have no effect.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, WIDTH'($urandom), $sformatf("msgIgn%0d", i));

    // Back-to-back loads.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, WIDTH'($urandom), $sformatf("b2b%0d", i));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 5) != 0);
      applyStimulus(r, l, WIDTH'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
